// File: rtl/bus2uart_master_pkg.sv
// -----------------------------------------------------------------------------
// bus2uart_master_pkg
// Shared constants for the uart2bus binary protocol as seen from the host side:
// command/prefix/ack byte values, the 3-bit FSM state encodings, the response
// record type and the combinational frame byte selector.
// No ports (package).
// -----------------------------------------------------------------------------
package bus2uart_master_pkg;

    localparam logic [7:0] BIN_PREFIX    = 8'h00;
    localparam logic [7:0] CMD_READ_1B   = 8'h12;
    localparam logic [7:0] CMD_WRITE_1B  = 8'h23;
    localparam logic [7:0] ACK_BYTE      = 8'h5A;
    // Transfer length byte: always a single data byte.
    localparam logic [7:0] LEN_ONE_BYTE  = 8'h01;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_TX_GAP   = 3'd2;
    localparam logic [2:0] ST_TX_WAIT  = 3'd3;
    localparam logic [2:0] ST_RSP_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [2:0] LAST_IDX_READ  = 3'd4;
    localparam logic [2:0] LAST_IDX_WRITE = 3'd5;

    typedef struct packed {
        logic       error;
        logic [7:0] rd_data;
    } rsp_t;

    // Byte idx of the outgoing command frame. Index 5 only exists for writes.
    function automatic logic [7:0] frame_byte(input logic        wr,
                                              input logic [2:0]  idx,
                                              input logic [15:0] addr,
                                              input logic [7:0]  data);
        logic [7:0] b;
        case (idx)
            3'd0:    b = BIN_PREFIX;
            3'd1:    b = wr ? CMD_WRITE_1B : CMD_READ_1B;
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            3'd4:    b = LEN_ONE_BYTE;
            default: b = data;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bus2uart_master_if.sv
// -----------------------------------------------------------------------------
// bus2uart_master_if
// Request/response channel between a local requester and bus2uart_master.
//  req_valid/req_ready/req_write/req_address/req_wr_data : request handshake
//  rsp_valid/rsp_rd_data/rsp_error                       : completion pulse
// Modports: master = requester side, slave = bus2uart_master side.
// -----------------------------------------------------------------------------
interface bus2uart_master_if #(
    parameter int AW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [7:0]    req_wr_data;
    logic          rsp_valid;
    logic [7:0]    rsp_rd_data;
    logic          rsp_error;

    modport master (
        output req_valid, req_write, req_address, req_wr_data,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wr_data,
        output req_ready, rsp_valid, rsp_rd_data, rsp_error
    );
endinterface

// File: rtl/bus2uart_timer.sv
// -----------------------------------------------------------------------------
// bus2uart_timer
// Reply timeout counter. Counts while enabled, saturates at all-ones.
//  clock   in  system clock
//  reset   in  asynchronous reset, active-low
//  clear   in  synchronous clear to zero (has priority over enable)
//  enable  in  count this cycle
//  expire  out count has reached TO_CYCLES-1
// -----------------------------------------------------------------------------
module bus2uart_timer #(
    parameter int              TO_W      = 20,
    parameter logic [TO_W-1:0] TO_CYCLES = 20'd600000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam logic [TO_W-1:0] LAST = TO_CYCLES - TO_W'(1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/bus2uart_master.sv
// -----------------------------------------------------------------------------
// bus2uart_master
// Host-side initiator for the uart2bus binary protocol. A single-byte read or
// write request is turned into a command frame sent byte-by-byte to a uart_top
// transmitter; the one-byte reply (data or ack) is parsed into a response.
//  clock        in   system clock
//  reset        in   asynchronous reset, active-low
//  bus          slave modport: req_* handshake in, rsp_* completion out
//  tx_data      out  byte to transmitter, valid with new_tx_data
//  new_tx_data  out  one-cycle transmit strobe
//  tx_busy      in   transmitter busy
//  rx_data      in   received byte, valid with new_rx_data
//  new_rx_data  in   one-cycle receive strobe
// AW must be 16: the frame carries exactly two address bytes, MSB first.
// -----------------------------------------------------------------------------
module bus2uart_master
    import bus2uart_master_pkg::*;
#(
    parameter int              AW        = 16,
    parameter int              TO_W      = 20,
    parameter logic [TO_W-1:0] TO_CYCLES = 20'd600000
) (
    input  logic                clock,
    input  logic                reset,
    bus2uart_master_if.slave    bus,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    input  logic                tx_busy,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data
);
    logic [2:0]    state;
    logic [2:0]    byte_idx;
    logic          rsp_valid_q;
    rsp_t          rsp_q;

    // Request fields captured at accept; the requester may change its inputs
    // afterwards. Data-only, so no reset is needed.
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wr_data_q;

    logic          accept;
    logic [2:0]    last_idx;
    logic [7:0]    cur_byte;
    logic          last_sent;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expire;

    assign accept      = bus.req_valid && (state == ST_IDLE);
    assign last_idx    = write_q ? LAST_IDX_WRITE : LAST_IDX_READ;
    assign cur_byte    = frame_byte(write_q, byte_idx, addr_q, wr_data_q);
    assign last_sent   = (state == ST_TX_WAIT) && !tx_busy && (byte_idx == last_idx);
    // The timeout window starts when the final command byte has left.
    assign timer_clear = last_sent;
    assign timer_en    = (state == ST_RSP_WAIT);

    bus2uart_timer #(
        .TO_W      (TO_W),
        .TO_CYCLES (TO_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clock) begin
        if (accept) begin
            write_q   <= bus.req_write;
            addr_q    <= bus.req_address;
            wr_data_q <= bus.req_wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            byte_idx    <= 3'd0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            new_tx_data <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        byte_idx <= 3'd0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data     <= cur_byte;
                        new_tx_data <= 1'b1;
                        state       <= ST_TX_GAP;
                    end
                end
                // The transmitter raises busy one cycle after the strobe, so
                // busy is not trustworthy here.
                ST_TX_GAP: state <= ST_TX_WAIT;
                ST_TX_WAIT: begin
                    if (!tx_busy) begin
                        if (byte_idx == last_idx) begin
                            state <= ST_RSP_WAIT;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= ST_SEND;
                        end
                    end
                end
                // A byte arriving in the expiry cycle still counts as a reply.
                ST_RSP_WAIT: begin
                    if (new_rx_data) begin
                        if (write_q) begin
                            rsp_q.rd_data <= 8'h00;
                            rsp_q.error   <= (rx_data != ACK_BYTE);
                        end else begin
                            rsp_q.rd_data <= rx_data;
                            rsp_q.error   <= 1'b0;
                        end
                        rsp_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else if (timer_expire) begin
                        rsp_q.rd_data <= 8'h00;
                        rsp_q.error   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                // rsp_valid is high for this single cycle.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_q.rd_data;
    assign bus.rsp_error   = rsp_q.error;

endmodule
